// File: rtl/shift_in_pkg.sv
// Shared types for the serial shift-in sequencer: FSM state encoding and default word width.
package shift_in_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_in_bit_cnt.sv
// Bit counter for the shift-in framing: synchronous clear beats increment, terminal count at TC_VAL.
// Latency: count visible the cycle after inc; tc is combinational from the count. No backpressure.
module shift_in_bit_cnt #(
    parameter int W      = 6,
    parameter int TC_VAL = 31
) (
    input  logic         i_CLK,
    input  logic         i_RST_N,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == W'(TC_VAL));

endmodule

// File: rtl/shift_in_ctrl.sv
// Sequencer for the external shift-in register: clears it, gates shifting, checks the sentinel, hands words out.
// Latency: last bit strobed in cycle k -> o_VALID from k+2; o_VALID/o_DATA held until i_READY. Optional macro SHIFT_IN_CTRL_PARITY_EN.
module shift_in_ctrl
    import shift_in_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_SDI,
    input  logic                  i_SVALID,
    input  logic                  i_ABORT,
    input  logic                  i_CLR_ERR,
    input  logic [DATA_WIDTH:0]   i_SR_Q,
    output logic                  o_SR_RST,
    output logic                  o_SR_EN,
    output logic                  o_SR_D,
    output logic [DATA_WIDTH-1:0] o_DATA,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic                  o_BUSY,
    output logic                  o_OVERFLOW,
    output logic                  o_SYNC_ERR,
    output logic                  o_PAR_ERR,
    output logic [CNT_WIDTH-1:0]  o_WORD_CNT
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
`ifdef SHIFT_IN_CTRL_PARITY_EN
    localparam int LAST_BIT = DATA_WIDTH;
`else
    localparam int LAST_BIT = DATA_WIDTH - 1;
`endif

    state_t         state_q, state_d;
    logic [BCW-1:0] bit_cnt;
    logic           bit_tc, bit_inc, bit_clr;
    logic           sr_en, load_word, accept, sync_set, par_set, par_bad;
    logic           ovf_set;

    shift_in_bit_cnt #(.W(BCW), .TC_VAL(LAST_BIT)) u_bit_cnt (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .clr     (bit_clr),
        .inc     (bit_inc),
        .cnt     (bit_cnt),
        .tc      (bit_tc)
    );

`ifdef SHIFT_IN_CTRL_PARITY_EN
    logic par_q;
    logic par_err_q;

    // The parity bit never enters the shift register; it is latched here instead.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (state_q == ST_SHIFT && i_SVALID && bit_tc) begin
                par_q <= i_SDI;
            end
            par_err_q <= par_set | (par_err_q & ~i_CLR_ERR);
        end
    end

    assign par_bad   = (^i_SR_Q[DATA_WIDTH-1:0]) ^ par_q;
    assign o_PAR_ERR = par_err_q;
`else
    assign par_bad   = 1'b0;
    assign o_PAR_ERR = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sr_en     = 1'b0;
        bit_inc   = 1'b0;
        bit_clr   = 1'b0;
        load_word = 1'b0;
        accept    = 1'b0;
        sync_set  = 1'b0;
        par_set   = 1'b0;
        if (i_ABORT) begin
            state_d = ST_CLEAR;
            bit_clr = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    state_d = ST_SHIFT;
                    bit_clr = 1'b1;
                end
                ST_SHIFT: begin
                    if (i_SVALID) begin
                        bit_inc = 1'b1;
`ifdef SHIFT_IN_CTRL_PARITY_EN
                        sr_en   = ~bit_tc;
`else
                        sr_en   = 1'b1;
`endif
                        if (bit_tc) begin
                            bit_clr = 1'b1;
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (!i_SR_Q[DATA_WIDTH]) begin
                        sync_set = 1'b1;
                        state_d  = ST_CLEAR;
                    end else if (par_bad) begin
                        par_set = 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        load_word = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (o_VALID && i_READY) begin
                        accept  = 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
                default: state_d = ST_CLEAR;
            endcase
        end
    end

    assign ovf_set = i_SVALID & (state_q != ST_SHIFT);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= ST_CLEAR;
            o_SR_RST   <= 1'b1;
            o_VALID    <= 1'b0;
            o_DATA     <= '0;
            o_WORD_CNT <= '0;
            o_OVERFLOW <= 1'b0;
            o_SYNC_ERR <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Registered so the clear pulse lines up exactly with the CLEAR cycle.
            o_SR_RST <= (state_d == ST_CLEAR);
            if (i_ABORT) begin
                o_VALID <= 1'b0;
            end else if (load_word) begin
                o_VALID <= 1'b1;
                o_DATA  <= i_SR_Q[DATA_WIDTH-1:0];
            end else if (accept) begin
                o_VALID <= 1'b0;
            end
            if (accept) begin
                o_WORD_CNT <= o_WORD_CNT + 1'b1;
            end
            o_OVERFLOW <= ovf_set  | (o_OVERFLOW & ~i_CLR_ERR);
            o_SYNC_ERR <= sync_set | (o_SYNC_ERR & ~i_CLR_ERR);
        end
    end

    assign o_SR_EN = sr_en;
    assign o_SR_D  = i_SDI;
    assign o_BUSY  = (state_q != ST_SHIFT) | (bit_cnt != '0);

endmodule

// File: tb/tb_shift_in_ctrl.sv
// Bench for shift_in_ctrl paired with a behavioural shift-in register (sentinel 1 reloaded on clear).
module tb_shift_in_ctrl;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdi = 1'b0, svalid = 1'b0, abort = 1'b0, clr_err = 1'b0, ready = 1'b0;
    logic          kill_sentinel = 1'b0;
    logic [DW:0]   sr_q, sr_q_dut;
    logic          sr_rst, sr_en, sr_d;
    logic [DW-1:0] data;
    logic          valid, busy, ovf, sync_err, par_err;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sr_q <= {{DW{1'b0}}, 1'b1};
        else if (sr_rst) sr_q <= {{DW{1'b0}}, 1'b1};
        else if (sr_en)  sr_q <= {sr_q[DW-1:0], sr_d};
    end

    assign sr_q_dut = {sr_q[DW] & ~kill_sentinel, sr_q[DW-1:0]};

    shift_in_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_SDI      (sdi),
        .i_SVALID   (svalid),
        .i_ABORT    (abort),
        .i_CLR_ERR  (clr_err),
        .i_SR_Q     (sr_q_dut),
        .o_SR_RST   (sr_rst),
        .o_SR_EN    (sr_en),
        .o_SR_D     (sr_d),
        .o_DATA     (data),
        .o_VALID    (valid),
        .i_READY    (ready),
        .o_BUSY     (busy),
        .o_OVERFLOW (ovf),
        .o_SYNC_ERR (sync_err),
        .o_PAR_ERR  (par_err),
        .o_WORD_CNT (word_cnt)
    );

    typedef struct {
        logic [DW-1:0] word;
        int            hold;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_shift();
        for (int i = 0; i < 10 && sr_rst; i++) step();
        chk("shift_entry", {63'd0, sr_rst}, 64'd0);
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sdi    = w[DW-1-i];
            svalid = 1'b1;
            step();
        end
        svalid = 1'b0;
    endtask

    task automatic send_parity(input logic p);
        sdi    = p;
        svalid = 1'b1;
        step();
        svalid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        send_bits(w, DW);
`ifdef SHIFT_IN_CTRL_PARITY_EN
        send_parity(^w);
`endif
    endtask

    task automatic recv_check(input logic [DW-1:0] w, input int hold,
                              input logic [DW-1:0] exp_data, input logic [CW-1:0] exp_wc);
        wait_shift();
        chk("busy_idle_shift", {63'd0, busy}, 64'd0);
        send_word(w);
        chk("valid_k+1", {63'd0, valid}, 64'd0);
        step();
        chk("valid_k+2", {63'd0, valid}, 64'd1);
        chk("data", {32'd0, data}, {32'd0, exp_data});
        for (int c = 0; c < hold; c++) begin
            step();
            chk("hold_valid", {63'd0, valid}, 64'd1);
            chk("hold_data", {32'd0, data}, {32'd0, exp_data});
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("valid_drop", {63'd0, valid}, 64'd0);
        chk("word_cnt", {56'd0, word_cnt}, {56'd0, exp_wc});
    endtask

    initial begin
        vecs[0] = '{32'd100,        0, 32'd100,        8'd1};
        vecs[1] = '{32'hFFFF_FFFF,  0, 32'hFFFF_FFFF,  8'd2};
        vecs[2] = '{32'h0000_0000,  3, 32'h0000_0000,  8'd3};
        vecs[3] = '{32'hA5A5_0F0F,  1, 32'hA5A5_0F0F,  8'd4};
        vecs[4] = '{32'h8000_0001,  0, 32'h8000_0001,  8'd5};

        // Reset state
        step();
        step();
        chk("rst_sr_rst", {63'd0, sr_rst}, 64'd1);
        chk("rst_sr_en", {63'd0, sr_en}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_data", {32'd0, data}, 64'd0);
        chk("rst_cnt", {56'd0, word_cnt}, 64'd0);
        chk("rst_flags", {61'd0, ovf, sync_err, par_err}, 64'd0);
        rst_n = 1'b1;

        // Table-driven word reception
        for (int v = 0; v < 5; v++) begin
            recv_check(vecs[v].word, vecs[v].hold, vecs[v].exp_data, vecs[v].exp_cnt);
            chk("par_err_clean", {63'd0, par_err}, 64'd0);
        end
        exp_cnt = 5;

        // Held word, strobes during HOLD overflow, second word only after restart
        wait_shift();
        send_word(32'hFFFF_FFFF);
        step();
        chk("t2_valid", {63'd0, valid}, 64'd1);
        for (int c = 0; c < 10; c++) begin
            sdi    = 1'b0;
            svalid = 1'b1;
            step();
        end
        svalid = 1'b0;
        chk("t2_hold_valid", {63'd0, valid}, 64'd1);
        chk("t2_hold_data", {32'd0, data}, 64'hFFFF_FFFF);
        chk("t2_overflow", {63'd0, ovf}, 64'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t2_ovf_clr", {63'd0, ovf}, 64'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t2_cnt1", {56'd0, word_cnt}, 64'd6);
        recv_check(32'h0000_0000, 0, 32'h0000_0000, 8'd7);
        exp_cnt = 7;

        // Abort part-way through a word
        wait_shift();
        send_bits(32'd10498, 17);
        chk("t3_busy_mid", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (valid) chk("t3_no_valid", {63'd0, valid}, 64'd0);
            step();
        end
        chk("t3_cnt", {56'd0, word_cnt}, 64'd7);
        recv_check(32'd256, 0, 32'd256, 8'd8);
        exp_cnt = 8;

        // Missing sentinel
        wait_shift();
        kill_sentinel = 1'b1;
        send_word(32'h1234_5678);
        step();
        kill_sentinel = 1'b0;
        chk("t4_sync_err", {63'd0, sync_err}, 64'd1);
        chk("t4_no_valid", {63'd0, valid}, 64'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t4_sync_clr", {63'd0, sync_err}, 64'd0);
        chk("t4_cnt", {56'd0, word_cnt}, 64'd8);

`ifdef SHIFT_IN_CTRL_PARITY_EN
        // Bad even-parity bit drops the word
        wait_shift();
        send_bits(32'd100, DW);
        send_parity(1'b0);
        step();
        chk("t6_par_err", {63'd0, par_err}, 64'd1);
        chk("t6_no_valid", {63'd0, valid}, 64'd0);
        chk("t6_cnt", {56'd0, word_cnt}, 64'd8);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t6_par_clr", {63'd0, par_err}, 64'd0);
        recv_check(32'd100, 0, 32'd100, 8'd9);
        exp_cnt = 9;
`endif

        // Word counter wrap
        while (exp_cnt < 256) begin
            exp_cnt++;
            recv_check(DW'(exp_cnt * 7), 0, DW'(exp_cnt * 7), CW'(exp_cnt));
        end
        chk("t5_wrap", {56'd0, word_cnt}, 64'd0);

        // Strobe in CLEAR, then async reset mid-SHIFT
        chk("t5_in_clear", {63'd0, sr_rst}, 64'd1);
        sdi    = 1'b1;
        svalid = 1'b1;
        step();
        svalid = 1'b0;
        chk("t5_ovf_clear", {63'd0, ovf}, 64'd1);
        wait_shift();
        send_bits(32'hF000_0000, 5);
        svalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sr_rst", {63'd0, sr_rst}, 64'd1);
        chk("ar_sr_en", {63'd0, sr_en}, 64'd0);
        chk("ar_valid", {63'd0, valid}, 64'd0);
        chk("ar_data", {32'd0, data}, 64'd0);
        chk("ar_cnt", {56'd0, word_cnt}, 64'd0);
        chk("ar_flags", {61'd0, ovf, sync_err, par_err}, 64'd0);
        svalid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
